// File: rtl/conv_ser_feeder.sv
// Input sequencer for the channel-serial convolution datapath: buffers the
// tap stream, replays each tap CHANNEL_NUM times and drains after every line.
module conv_ser_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int MTRX_NUM    = 8,
    parameter int STRING_LEN  = 224,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    output logic                         valid_o,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int PW  = DATA_WIDTH + 4;
    localparam int CW  = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int GW  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
    localparam int TW  = (MTRX_NUM    > 1) ? $clog2(MTRX_NUM)    : 1;
    localparam int SW  = (STRING_LEN  > 1) ? $clog2(STRING_LEN)  : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL_NUM - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TAP_LAST = TW'(MTRX_NUM - 1);
    localparam logic [SW-1:0] POS_LAST = SW'(STRING_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // Packet layout: {sof, eof, sop, eop, data}
    localparam int I_SOF = PW - 1;
    localparam int I_EOF = PW - 2;
    localparam int I_SOP = PW - 3;
    localparam int I_EOP = PW - 4;

    logic [1:0]    r_state;
    logic [CW-1:0] r_ch_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [TW-1:0] r_tap_cnt;
    logic [SW-1:0] r_pos_cnt;
    logic          r_buf_full;
    logic [PW-1:0] r_buf_pkt;
    logic [PW-1:0] r_hold_pkt;
    logic          r_err;

    logic [PW-1:0] w_in_pkt;
    logic          w_accept;
    logic          w_ch_last;
    logic          w_gap_last;
    logic          w_start;
    logic          w_reload;
    logic          w_load_buf;
    logic          w_load_in;
    logic          w_buf_wr;
    logic [TW-1:0] w_cur_tap;
    logic [SW-1:0] w_cur_pos;
    logic          w_at_last;

    assign w_in_pkt   = {sof_i, eof_i, sop_i, eop_i, data_i};
    assign w_accept   = valid_i && !r_buf_full;
    assign w_ch_last  = (r_ch_cnt == CH_LAST);
    assign w_gap_last = (r_gap_cnt == GAP_LAST);

    // The last GAP cycle behaves like IDLE so a buffered line start follows
    // the drain gap with no extra bubble.
    assign w_start    = (r_state == S_IDLE) || ((r_state == S_GAP) && w_gap_last);
    assign w_reload   = (r_state == S_EMIT) && w_ch_last && !r_hold_pkt[I_EOP] && r_buf_full;
    assign w_load_buf = (w_start && r_buf_full) || w_reload;
    assign w_load_in  = w_start && !r_buf_full && w_accept;
    assign w_buf_wr   = w_accept && !w_load_in;

    assign w_cur_tap  = sop_i ? '0 : r_tap_cnt;
    assign w_cur_pos  = sop_i ? '0 : r_pos_cnt;
    assign w_at_last  = (w_cur_tap == TAP_LAST) && (w_cur_pos == POS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf_pkt  <= '0;
            r_hold_pkt <= '0;
        end else begin
            if (w_buf_wr) begin
                r_buf_full <= 1'b1;
                r_buf_pkt  <= w_in_pkt;
            end else if (w_load_buf) begin
                r_buf_full <= 1'b0;
            end
            if (w_load_buf) begin
                r_hold_pkt <= r_buf_pkt;
            end else if (w_load_in) begin
                r_hold_pkt <= w_in_pkt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ch_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_buf || w_load_in) begin
                        r_state  <= S_EMIT;
                        r_ch_cnt <= '0;
                    end
                end
                S_EMIT: begin
                    if (w_ch_last) begin
                        r_ch_cnt <= '0;
                        if (r_hold_pkt[I_EOP]) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end else if (!r_buf_full) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_ch_cnt <= r_ch_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_last) begin
                        r_gap_cnt <= '0;
                        r_state   <= (w_load_buf || w_load_in) ? S_EMIT : S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tap_cnt <= '0;
            r_pos_cnt <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            if (w_cur_tap == TAP_LAST) begin
                r_tap_cnt <= '0;
                r_pos_cnt <= (w_cur_pos == POS_LAST) ? '0 : w_cur_pos + 1'b1;
            end else begin
                r_tap_cnt <= w_cur_tap + 1'b1;
                r_pos_cnt <= w_cur_pos;
            end
            r_err <= (eop_i ^ w_at_last) || (r_err && !sof_i);
        end
    end

    assign ready_o = !r_buf_full;
    assign valid_o = (r_state == S_EMIT);
    assign data_o  = r_hold_pkt[DATA_WIDTH-1:0];
    assign sop_o   = valid_o && (r_ch_cnt == '0) && r_hold_pkt[I_SOP];
    assign sof_o   = valid_o && (r_ch_cnt == '0) && r_hold_pkt[I_SOF];
    assign eop_o   = valid_o && w_ch_last && r_hold_pkt[I_EOP];
    assign eof_o   = valid_o && w_ch_last && r_hold_pkt[I_EOF];
    assign busy_o  = (r_state != S_IDLE) || r_buf_full;
    assign err_o   = r_err;

endmodule
